// File: rtl/proc_pkg.sv
// Purpose : shared definitions for the fetch unit and control_unit (instruction
//           format, HALT opcode, fetch FSM states). Both sides import this package
//           so each field width, bit position and opcode constant exists once.
// Ports   : none (package).
package proc_pkg;

  // Instruction word format
  localparam int INSTR_W   = 32;
  localparam int OPCODE_W  = 5;
  localparam int REG_W     = 5;
  localparam int FUNCT_W   = 4;

  // IR field positions (LSB of each field). IR[11:4] is reserved.
  localparam int IR_OPC_LSB   = 27;
  localparam int IR_RD_LSB    = 22;
  localparam int IR_RS_LSB    = 17;
  localparam int IR_RT_LSB    = 12;
  localparam int IR_RSVD_LSB  = 4;
  localparam int IR_RSVD_W    = 8;
  localparam int IR_FUNCT_LSB = 0;

  // Opcodes shared with control_unit
  localparam logic [OPCODE_W-1:0] OPC_HALT = 5'b11111;

  // Decoded instruction fields as presented to the decoder
  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [REG_W-1:0]    rd;
    logic [REG_W-1:0]    rs;
    logic [REG_W-1:0]    rt;
    logic [FUNCT_W-1:0]  funct;
  } instr_fields_t;

  // Fetch FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_t;

  function automatic logic is_halt(input logic [OPCODE_W-1:0] opc);
    return (opc == OPC_HALT);
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Purpose : wrapping program counter, +1 per enabled cycle, modulo 2^ADDR_W.
// Latency : new value visible the cycle after i_inc is sampled high.
// Backpr. : none; increments only when the owner asserts i_inc.
// Ports   : clk, reset (sync, active-high, loads RESET_PC), i_inc (increment
//           enable), o_pc (current count).
module pc_reg #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;

  // Natural overflow of the ADDR_W-bit add gives the wrap (all-ones -> 0).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (i_inc) begin
      r_pc <= r_pc + ADDR_W'(1);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch_unit.sv
// Purpose : fetch instruction words over req/ack, hold them in the IR and hand
//           the split fields to the decoder over valid/ready; stop on HALT.
// Latency : ack in cycle N -> instr_valid in N+1; ready in M -> next req in M+1
//           (peak one instruction per 2 cycles).
// Backpr. : IR and fields hold while instr_valid && !instr_ready; no new fetch
//           is issued until the current instruction is consumed.
// Ports   : clk, reset (sync, active-high), run (fetch enable level);
//           imem_req/imem_addr/imem_rdata/imem_ack (memory handshake);
//           instr_valid/instr_ready + opcode/rd/rs/rt/funct (decoder side);
//           pc (program counter), halted (HALT consumed, sticky until reset).
module instr_fetch_unit
  import proc_pkg::*;
#(
  parameter int          ADDR_W   = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic [INSTR_W-1:0]  imem_rdata,
  input  logic                imem_ack,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [OPCODE_W-1:0] opcode,
  output logic [REG_W-1:0]    rd,
  output logic [REG_W-1:0]    rs,
  output logic [REG_W-1:0]    rt,
  output logic [FUNCT_W-1:0]  funct,
  output logic [ADDR_W-1:0]   pc,
  output logic                halted
);

  localparam logic [ADDR_W-1:0] LP_RESET_PC = ADDR_W'(RESET_PC);

  fetch_state_t        r_state;
  fetch_state_t        w_state_nxt;
  logic [INSTR_W-1:0]  r_ir;
  instr_fields_t       w_fields;
  logic [ADDR_W-1:0]   w_pc;
  logic                w_ir_load;
  logic                w_pc_inc;
  logic                w_imem_req;
  logic                w_instr_valid;
  logic                w_halted;
  logic                w_unused_rsvd;

  // Handshake qualifiers: an ack is only meaningful while requesting, a ready
  // only while issuing; anything else is dropped on the floor.
  assign w_ir_load = (r_state == ST_REQ)   && imem_ack;
  assign w_pc_inc  = (r_state == ST_ISSUE) && instr_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and state-decoded outputs. Outputs depend on r_state only, so
  // there is no combinational path from any input to req/valid/halted.
  always_comb begin
    w_state_nxt   = r_state;
    w_imem_req    = 1'b0;
    w_instr_valid = 1'b0;
    w_halted      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (run) begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        w_imem_req = 1'b1;
        // Dropping run here does not cancel the outstanding fetch.
        if (imem_ack) begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_instr_valid = 1'b1;
        if (instr_ready) begin
          if (is_halt(w_fields.opcode)) begin
            w_state_nxt = ST_HALTED;
          end else if (run) begin
            w_state_nxt = ST_REQ;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_HALTED: begin
        w_halted    = 1'b1;
        w_state_nxt = ST_HALTED;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Instruction register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ir <= '0;
    end else if (w_ir_load) begin
      r_ir <= imem_rdata;
    end
  end

  // Field split
  assign w_fields.opcode = r_ir[IR_OPC_LSB   +: OPCODE_W];
  assign w_fields.rd     = r_ir[IR_RD_LSB    +: REG_W];
  assign w_fields.rs     = r_ir[IR_RS_LSB    +: REG_W];
  assign w_fields.rt     = r_ir[IR_RT_LSB    +: REG_W];
  assign w_fields.funct  = r_ir[IR_FUNCT_LSB +: FUNCT_W];

  // Reserved IR bits are carried but have no consumer.
  assign w_unused_rsvd = ^r_ir[IR_RSVD_LSB +: IR_RSVD_W];

  // Program counter; advances exactly once per consumed instruction.
  pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (LP_RESET_PC)
  ) u_pc_reg (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_pc_inc),
    .o_pc  (w_pc)
  );

  // The PC only changes on consumption, so it is the fetch address for the
  // whole REQ phase and can drive imem_addr directly.
  assign imem_addr   = w_pc;
  assign pc          = w_pc;
  assign imem_req    = w_imem_req;
  assign instr_valid = w_instr_valid;
  assign halted      = w_halted;
  assign opcode      = w_fields.opcode;
  assign rd          = w_fields.rd;
  assign rs          = w_fields.rs;
  assign rt          = w_fields.rt;
  assign funct       = w_fields.funct;

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

- Fetches instruction words from instruction memory over a req/ack handshake.
- Holds each word in an instruction register (IR) and splits it into opcode, funct and register fields.
- Presents those fields to `control_unit` with a valid/ready handshake, which supplies the opcode that `control_unit` decodes into `ALUop`/`regWrite`.
- Steps a wrapping program counter once per consumed instruction and stops permanently on the HALT opcode.

## Interface

Parameters:
- `ADDR_W`, 8: PC and instruction-memory address width.
- `RESET_PC`, 0: PC value loaded on reset.

Ports:
- `clk`  in  1: the single clock; all state changes on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `run`  in  1: level-sensitive fetch enable.
- `imem_req`  out  1: fetch request, held high until `imem_ack`.
- `imem_addr`  out  ADDR_W: fetch address, equal to `pc` while `imem_req` is high.
- `imem_rdata`  in  32: instruction word, sampled when `imem_ack` is high.
- `imem_ack`  in  1: one-cycle acknowledge with data valid.
- `instr_valid`  out  1: IR holds an instruction not yet taken by the decoder.
- `instr_ready`  in  1: decoder accepts the instruction this cycle.
- `opcode`  out  5: IR[31:27].
- `rd`  out  5: IR[26:22].
- `rs`  out  5: IR[21:17].
- `rt`  out  5: IR[16:12].
- `funct`  out  4: IR[3:0]. IR[11:4] is reserved and ignored.
- `pc`  out  ADDR_W: current program counter.
- `halted`  out  1: HALT instruction consumed.

## Operation

FSM states: IDLE, REQ, ISSUE, HALTED.

- **Reset:** state=IDLE, `pc`=RESET_PC, IR=0. Reset values of every output: `imem_req`=0, `imem_addr`=RESET_PC, `instr_valid`=0, `halted`=0, all IR fields 0.
- **IDLE:**
  - `run`=1 → REQ.
  - Otherwise stay in IDLE.
- **REQ:** `imem_req`=1 and `imem_addr`=`pc`.
  - `imem_ack`=1 → IR←`imem_rdata`, go to ISSUE.
  - `run` falling while in REQ does not abort the fetch; the block waits for `imem_ack`.
- **ISSUE:** `instr_valid`=1. IR fields are stable and held until `instr_ready`=1. When `instr_ready`=1:
  - `pc`←`pc`+1, modulo 2^ADDR_W (0xFF → 0x00 at ADDR_W=8).
  - Consumed `opcode`==5'b11111 (HALT) → HALTED.
  - Else `run`=1 → REQ.
  - Else → IDLE.
- **HALTED:**
  - `halted`=1, `imem_req`=0, `instr_valid`=0.
  - Only `reset` leaves this state.
- **Ignored inputs:**
  - `imem_ack` outside REQ is ignored; IR is unchanged.
  - `instr_ready` outside ISSUE is ignored.
- **Output decode:** `imem_req`, `instr_valid` and `halted` are decoded from the registered state, with no combinational path from inputs.
- **Reset during operation:** `reset` in any state (including REQ before ack, or ISSUE before ready) takes effect at that edge. `imem_req` and `instr_valid` are 0 the following cycle, and any pending acknowledge is discarded.

## Timing

- Reset released at edge E with `run`=1: IDLE during cycle E+0, `imem_req`=1 from E+1.
- `imem_ack` in cycle N → `instr_valid`=1 in cycle N+1.
- `instr_ready` in cycle M with `run`=1 → `imem_req`=1 in cycle M+1 with the incremented `imem_addr`.
- Peak throughput is one instruction per 2 cycles, with zero-wait ack and ready tied high.
- `imem_ack` in the same cycle `imem_req` first rises is legal.
- Memory latency is unbounded.
- HALT: `halted`=1 from the cycle after the HALT instruction is accepted. `pc` has already advanced past the HALT address.

## Structure

Shared package `proc_pkg` holds:
- Opcode width 5 and funct width 4.
- IR field bit positions.
- The HALT opcode 5'b11111.
- The FSM state enum.

`control_unit`'s opcode and funct constants are to be migrated into `proc_pkg` so both sides share one definition.

Sub-module: `pc_reg`, a parameterised wrapping counter with synchronous reset to RESET_PC and an increment enable driven by ISSUE && `instr_ready`.

## Test plan

- **Straight-line fetch:** memory words 0x10000001, 0x10000002, 0x10000003 at addresses 0–2. `run`=1, zero-wait ack, `instr_ready`=1 → `opcode`=5'b00010 with `funct`=1, 2, 3 on successive valid cycles; `pc` goes 0→1→2→3; valid every 2nd cycle.
- **Backpressure:** hold `instr_ready`=0 for 5 cycles → `instr_valid` and fields stable for all 5 cycles, `pc` unchanged, `imem_req`=0.
- **Slow memory:** ack arrives 4 cycles after request; `run` is dropped mid-wait → `imem_req` held until ack, instruction issued once, then IDLE.
- **HALT:** word 0xF8000000 at address 2 → `halted`=1 one cycle after acceptance, `pc`=3, no further `imem_req` even with `run`=1.
- **PC wrap:** ADDR_W=8, RESET_PC=0xFE → fetch addresses 0xFE, 0xFF, 0x00.
- **Reset mid-handshake:** assert `reset` during REQ and again during ISSUE → next cycle `imem_req`=0, `instr_valid`=0, `pc`=RESET_PC, and a late `imem_ack` does not load IR.
